memory_responder: RTL and testbench

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_pkg.sv | 20 ++
 rtl/memory_responder_channel.sv | 116 +++++++++++
 rtl/memory_responder.sv | 75 +++++++
 tb/tb_memory_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared types for the memory responder: the per-channel FSM state, the
// captured operation kind and the latency-counter width.
package memory_responder_pkg;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int unsigned CNT_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND,
    DRAIN
  } chan_state_e;

  typedef enum logic {
    READ,
    WRITE
  } op_e;

endpackage

// File: rtl/memory_responder_channel.sv
// One request channel of the memory responder.
// Accepts a read or write request from IDLE, waits LATENCY cycles, pulses the
// matching ready output for one cycle, then waits for the request to drop.
//   clk, reset             : clock, synchronous active-high reset
//   rd_req_i / wr_req_i    : read / write request, held until served
//   rd_addr_i / wr_addr_i  : request addresses
//   wr_data_i              : write data
//   mem_word_i             : storage word at addr_o (combinational from top)
//   addr_o, wr_data_o      : captured address / write data
//   commit_o               : write commits to storage at the next edge
//   rd_ready_o, wr_ready_o : one-cycle completion pulses
//   rd_data_o              : last read response, held until the next one
module memory_responder_channel
  import memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_req_i,
  input  logic                 wr_req_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  input  logic [DATA_BITS-1:0] mem_word_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic [DATA_BITS-1:0] wr_data_o,
  output logic                 commit_o,
  output logic                 rd_ready_o,
  output logic                 wr_ready_o,
  output logic [DATA_BITS-1:0] rd_data_o
);

  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);

  chan_state_e          state_q, state_d;
  op_e                  op_q, op_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic                 held_req;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    commit_o = 1'b0;
    // Only the request that was accepted keeps the transaction alive.
    held_req = (op_q == READ) ? rd_req_i : wr_req_i;

    unique case (state_q)
      IDLE: begin
        if (rd_req_i) begin
          op_d    = READ;
          addr_d  = rd_addr_i;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end else if (wr_req_i) begin
          op_d    = WRITE;
          addr_d  = wr_addr_i;
          wdata_d = wr_data_i;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!held_req) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d  = RESPOND;
          commit_o = (op_q == WRITE);
          if (op_q == READ) rdata_d = mem_word_i;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
        end
      end
      RESPOND: state_d = DRAIN;
      DRAIN: begin
        if (!held_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign addr_o     = addr_q;
  assign wr_data_o  = wdata_q;
  assign rd_data_o  = rdata_q;
  assign rd_ready_o = (state_q == RESPOND) && (op_q == READ);
  assign wr_ready_o = (state_q == RESPOND) && (op_q == WRITE);

endmodule

// File: rtl/memory_responder.sv
// Multi-channel memory responder: shared storage of 2^ADDR_BITS words served
// by NUM_CHANNELS independent fixed-latency request channels.
//   clk, reset         : clock, synchronous active-high reset
//   mem_read_request   : per-channel read request, held until served
//   mem_read_address   : per-channel read address
//   mem_read_ready     : per-channel one-cycle read-complete pulse
//   mem_read_data      : per-channel read data, held until the next read
//   mem_write_request  : per-channel write request, held until served
//   mem_write_address  : per-channel write address
//   mem_write_data     : per-channel write data
//   mem_write_ready    : per-channel one-cycle write-complete pulse
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned NUM_CHANNELS = 1,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned WRITE_ENABLE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] mem_read_request,
  input  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_read_ready,
  output logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] mem_write_request,
  input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_write_ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  // Storage is not reset so its contents survive a reset pulse.
  logic [DATA_BITS-1:0]    mem_q [DEPTH] = '{default: '0};
  logic [ADDR_BITS-1:0]    ch_addr  [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    ch_wdata [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ch_commit;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    memory_responder_channel #(
      .ADDR_BITS(ADDR_BITS),
      .DATA_BITS(DATA_BITS),
      .LATENCY  (LATENCY)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .rd_req_i  (mem_read_request[c]),
      .wr_req_i  (mem_write_request[c]),
      .rd_addr_i (mem_read_address[c]),
      .wr_addr_i (mem_write_address[c]),
      .wr_data_i (mem_write_data[c]),
      .mem_word_i(mem_q[ch_addr[c]]),
      .addr_o    (ch_addr[c]),
      .wr_data_o (ch_wdata[c]),
      .commit_o  (ch_commit[c]),
      .rd_ready_o(mem_read_ready[c]),
      .wr_ready_o(mem_write_ready[c]),
      .rd_data_o (mem_read_data[c])
    );
  end

  // Channels are visited from highest to lowest index, so the last
  // non-blocking write to a shared address -- the lowest channel -- wins.
  // Same-edge reads sample the pre-write value.
  always_ff @(posedge clk) begin
    if (!reset && (WRITE_ENABLE != 0)) begin
      for (int unsigned i = NUM_CHANNELS; i > 0; i--) begin
        if (ch_commit[i-1]) mem_q[ch_addr[i-1]] <= ch_wdata[i-1];
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Directed self-checking bench for memory_responder: a two-channel writable
// instance and a single-channel read-only instance, both with LATENCY=2.
module tb_memory_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Two-channel writable instance
  logic [1:0]  rd_req, wr_req, rd_rdy, wr_rdy;
  logic [7:0]  rd_addr [2];
  logic [7:0]  wr_addr [2];
  logic [15:0] wr_data [2];
  logic [15:0] rd_data [2];

  // Single-channel read-only instance
  logic [0:0]  ro_rd_req, ro_wr_req, ro_rd_rdy, ro_wr_rdy;
  logic [7:0]  ro_rd_addr [1];
  logic [7:0]  ro_wr_addr [1];
  logic [15:0] ro_wr_data [1];
  logic [15:0] ro_rd_data [1];

  memory_responder #(
    .ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(2), .LATENCY(2), .WRITE_ENABLE(1)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_read_request(rd_req), .mem_read_address(rd_addr),
    .mem_read_ready(rd_rdy), .mem_read_data(rd_data),
    .mem_write_request(wr_req), .mem_write_address(wr_addr),
    .mem_write_data(wr_data), .mem_write_ready(wr_rdy)
  );

  memory_responder #(
    .ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(1), .LATENCY(2), .WRITE_ENABLE(0)
  ) dut_ro (
    .clk(clk), .reset(reset),
    .mem_read_request(ro_rd_req), .mem_read_address(ro_rd_addr),
    .mem_read_ready(ro_rd_rdy), .mem_read_data(ro_rd_data),
    .mem_write_request(ro_wr_req), .mem_write_address(ro_wr_addr),
    .mem_write_data(ro_wr_data), .mem_write_ready(ro_wr_rdy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel_rdy(input bit ro, input int ch, input bit wr);
    if (ro) return wr ? ro_wr_rdy[0] : ro_rd_rdy[0];
    return wr ? wr_rdy[ch] : rd_rdy[ch];
  endfunction

  function automatic logic [15:0] sel_data(input bit ro, input int ch);
    if (ro) return ro_rd_data[0];
    return rd_data[ch];
  endfunction

  task automatic set_req(input bit ro, input int ch, input bit wr, input logic v);
    if (ro) begin
      if (wr) ro_wr_req[0] = v; else ro_rd_req[0] = v;
    end else begin
      if (wr) wr_req[ch] = v; else rd_req[ch] = v;
    end
  endtask

  task automatic set_ad(input bit ro, input int ch, input bit wr,
                        input logic [7:0] a, input logic [15:0] d);
    if (ro) begin
      if (wr) begin ro_wr_addr[0] = a; ro_wr_data[0] = d; end
      else ro_rd_addr[0] = a;
    end else begin
      if (wr) begin wr_addr[ch] = a; wr_data[ch] = d; end
      else rd_addr[ch] = a;
    end
  endtask

  // Full handshake from IDLE. Ready is expected on the third edge after the
  // request is driven (acceptance edge + LATENCY). Inputs are scrambled right
  // after acceptance, so the captured address/data must be what gets used.
  task automatic op(input bit ro, input int ch, input bit wr, input logic [7:0] a,
                    input logic [15:0] d, input logic [15:0] exp_rd, input string tag);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 1'b0;
    set_ad(ro, ch, wr, a, d);
    set_req(ro, ch, wr, 1'b1);
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      if (cyc == 1) set_ad(ro, ch, wr, ~a, ~d);
      seen = sel_rdy(ro, ch, wr);
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd3);
    if (!wr) chk({tag, "_data"}, 32'(sel_data(ro, ch)), 32'(exp_rd));
    set_req(ro, ch, wr, 1'b0);
    tick();
    chk({tag, "_pulse_width"}, 32'(sel_rdy(ro, ch, wr)), 32'd0);
    if (!wr) chk({tag, "_data_held"}, 32'(sel_data(ro, ch)), 32'(exp_rd));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int pulses;
    reset     = 1'b1;
    rd_req    = '0;
    wr_req    = '0;
    ro_rd_req = '0;
    ro_wr_req = '0;
    for (int i = 0; i < 2; i++) begin
      rd_addr[i] = '0; wr_addr[i] = '0; wr_data[i] = '0;
    end
    ro_rd_addr[0] = '0; ro_wr_addr[0] = '0; ro_wr_data[0] = '0;
    repeat (3) tick();
    chk("reset_rd_rdy", 32'(rd_rdy), 32'd0);
    chk("reset_wr_rdy", 32'(wr_rdy), 32'd0);
    chk("reset_rd_data0", 32'(rd_data[0]), 32'd0);
    chk("reset_rd_data1", 32'(rd_data[1]), 32'd0);
    reset = 1'b0;
    tick();

    // Basic write then read-back
    op(0, 0, 1, 8'h10, 16'hBEEF, 16'h0000, "wr_beef");
    op(0, 0, 0, 8'h10, 16'h0000, 16'hBEEF, "rd_beef");

    // Same-cycle writes from both channels to one address: channel 0 wins
    wr_addr[0] = 8'h20; wr_data[0] = 16'h1111;
    wr_addr[1] = 8'h20; wr_data[1] = 16'h2222;
    wr_req = 2'b11;
    cyc = 0;
    while (wr_rdy[0] !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    chk("dual_wr_latency", 32'(cyc), 32'd3);
    chk("dual_wr_both_ready", 32'(wr_rdy), 32'h3);
    wr_req = 2'b00;
    tick(); tick();
    op(0, 0, 0, 8'h20, 16'h0000, 16'h1111, "rd_arb_ch0");
    op(0, 1, 0, 8'h20, 16'h0000, 16'h1111, "rd_arb_ch1");

    // Same-cycle write (ch0) and read (ch1) of one address: read sees old data
    wr_addr[0] = 8'h10; wr_data[0] = 16'h7777; wr_req[0] = 1'b1;
    rd_addr[1] = 8'h10; rd_req[1] = 1'b1;
    cyc = 0;
    while (rd_rdy[1] !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    chk("rw_collide_latency", 32'(cyc), 32'd3);
    chk("rw_collide_wr_ready", 32'(wr_rdy[0]), 32'd1);
    chk("rw_collide_old_data", 32'(rd_data[1]), 32'hBEEF);
    wr_req[0] = 1'b0; rd_req[1] = 1'b0;
    tick(); tick();
    op(0, 1, 0, 8'h10, 16'h0000, 16'h7777, "rd_after_collide");

    // Read and write both requested on ch0: read first, write stays pending
    rd_addr[0] = 8'h10; rd_req[0] = 1'b1;
    wr_addr[0] = 8'h60; wr_data[0] = 16'h6666; wr_req[0] = 1'b1;
    cyc = 0;
    while (rd_rdy[0] !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    chk("prio_rd_latency", 32'(cyc), 32'd3);
    chk("prio_rd_data", 32'(rd_data[0]), 32'h7777);
    chk("prio_wr_not_ready", 32'(wr_rdy[0]), 32'd0);
    rd_req[0] = 1'b0;
    cyc = 0;
    while (wr_rdy[0] !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    // RESPOND->DRAIN, DRAIN->IDLE, accept, then LATENCY
    chk("prio_wr_latency", 32'(cyc), 32'd5);
    wr_req[0] = 1'b0;
    tick(); tick();
    op(0, 0, 0, 8'h60, 16'h0000, 16'h6666, "rd_pending_wr");

    // Request held after ready: exactly one pulse
    rd_addr[0] = 8'h20; rd_req[0] = 1'b1;
    cyc = 0;
    while (rd_rdy[0] !== 1'b1 && cyc < 20) begin tick(); cyc++; end
    pulses = (rd_rdy[0] === 1'b1) ? 1 : 0;
    repeat (6) begin tick(); if (rd_rdy[0] === 1'b1) pulses++; end
    chk("held_req_one_pulse", 32'(pulses), 32'd1);
    rd_req[0] = 1'b0;
    tick(); tick();

    // Aborts during BUSY: no pulses, no commit
    rd_addr[0] = 8'h30; rd_req[0] = 1'b1;
    tick();
    rd_req[0] = 1'b0;
    pulses = 0;
    repeat (5) begin tick(); if (rd_rdy[0] === 1'b1) pulses++; end
    chk("abort_rd_no_pulse", 32'(pulses), 32'd0);
    wr_addr[0] = 8'h30; wr_data[0] = 16'h5555; wr_req[0] = 1'b1;
    tick();
    wr_req[0] = 1'b0;
    pulses = 0;
    repeat (5) begin tick(); if (wr_rdy[0] === 1'b1) pulses++; end
    chk("abort_wr_no_pulse", 32'(pulses), 32'd0);
    op(0, 0, 0, 8'h30, 16'h0000, 16'h0000, "rd_after_abort");

    // Reset during BUSY of a write, request held through reset
    wr_addr[0] = 8'h40; wr_data[0] = 16'hAAAA; wr_req[0] = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_wr_rdy", 32'(wr_rdy), 32'd0);
    chk("rst_mid_rd_data0", 32'(rd_data[0]), 32'd0);
    tick();
    chk("rst_dominates_wr_rdy", 32'(wr_rdy), 32'd0);
    reset = 1'b0; wr_req[0] = 1'b0;
    tick(); tick();
    op(0, 0, 0, 8'h40, 16'h0000, 16'h0000, "rd_after_reset");
    op(0, 0, 0, 8'h10, 16'h0000, 16'h7777, "storage_kept_reset");

    // Read-only instance
    op(1, 0, 1, 8'h50, 16'h1234, 16'h0000, "ro_wr");
    op(1, 0, 0, 8'h50, 16'h0000, 16'h0000, "ro_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
